// File: rtl/ddr_app_pkg.sv
// Shared MIG command encodings and controller state type for the DDR app-port controller.
package ddr_app_pkg;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        CALIB,
        IDLE,
        READ,
        WRITE
    } state_t;

endpackage

// File: rtl/ddr_resp_fifo.sv
// Read-response buffer: first-word fall-through, zero-latency head, never backpressures its writer.
// A write into a full FIFO is taken only if the same cycle also pops; otherwise the beat is discarded.
module ddr_resp_fifo #(
    parameter int DATA_W   = 256,
    parameter int RD_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        empty,
    output logic [$clog2(RD_DEPTH):0]   count
);

    localparam int AW = $clog2(RD_DEPTH);

    logic [DATA_W-1:0] mem [RD_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              full;
    logic              do_rd;
    logic              do_wr;

    // Extra pointer bit distinguishes full from empty; depth is a power of two.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = count[AW];
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/ddr_app_ctrl.sv
// Single-outstanding-command bridge from a valid/ready line interface to the MIG app port.
// Reads are credited against the response buffer so returning data can never be refused.
module ddr_app_ctrl
    import ddr_app_pkg::*;
#(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 256,
    parameter int APP_ADDR_W = 28,
    parameter int ADDR_LSB   = 3,
    parameter int RD_DEPTH   = 8
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic [ADDR_W-1:0]           req_addr,
    input  logic [DATA_W-1:0]           req_data,
    input  logic [DATA_W/8-1:0]         req_be,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [DATA_W-1:0]           resp_data,
    output logic [APP_ADDR_W-1:0]       app_addr,
    output logic [2:0]                  app_cmd,
    output logic                        app_en,
    input  logic                        app_rdy,
    output logic [DATA_W-1:0]           app_wdf_data,
    output logic [DATA_W/8-1:0]         app_wdf_mask,
    output logic                        app_wdf_wren,
    output logic                        app_wdf_end,
    input  logic                        app_wdf_rdy,
    input  logic [DATA_W-1:0]           app_rd_data,
    input  logic                        app_rd_data_valid,
    input  logic                        app_rd_data_end,
    input  logic                        init_calib_complete,
    output logic                        calib_done,
    output logic [$clog2(RD_DEPTH):0]   rd_credits_used,
    output logic                        err_rd_overflow
);

    localparam int BE_W = DATA_W / 8;
    localparam int CW   = $clog2(RD_DEPTH) + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(RD_DEPTH);

    state_t            state;
    logic              calib_q;
    logic              hold_write;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [BE_W-1:0]   hold_be;
    logic              accept;
    logic              rd_issue;
    logic              cmd_done;
    logic              dat_done;
    logic              deq;
    logic              credit_dec;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;
    logic              unused_rd_data_end;

    assign unused_rd_data_end = app_rd_data_end;

    assign calib_done = (state != CALIB);
    assign req_ready  = (state == IDLE) && (rd_credits_used < CREDIT_MAX);
    assign accept     = req_valid && req_ready;
    assign rd_issue   = (state == READ) && app_en && app_rdy;
    assign cmd_done   = !app_en || app_rdy;
    assign dat_done   = !app_wdf_wren || app_wdf_rdy;
    assign resp_valid = !fifo_empty;
    assign deq        = resp_valid && resp_ready;
    assign credit_dec = deq && (rd_credits_used != '0);
    assign fifo_full  = (fifo_count == CREDIT_MAX);

    always_comb begin
        app_addr = '0;
        app_addr[ADDR_LSB +: ADDR_W] = hold_addr;
    end

    assign app_cmd      = hold_write ? CMD_WRITE : CMD_READ;
    assign app_wdf_data = hold_data;
    assign app_wdf_mask = ~hold_be;
    assign app_wdf_end  = app_wdf_wren;

    // Command and write-data channels handshake independently during a write.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= CALIB;
            calib_q      <= 1'b0;
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
        end else begin
            calib_q <= init_calib_complete;
            unique case (state)
                CALIB: begin
                    if (calib_q) state <= IDLE;
                end
                IDLE: begin
                    if (accept) begin
                        app_en       <= 1'b1;
                        app_wdf_wren <= req_write;
                        state        <= req_write ? WRITE : READ;
                    end
                end
                READ: begin
                    if (app_rdy) begin
                        app_en <= 1'b0;
                        state  <= IDLE;
                    end
                end
                WRITE: begin
                    if (app_rdy)     app_en       <= 1'b0;
                    if (app_wdf_rdy) app_wdf_wren <= 1'b0;
                    if (cmd_done && dat_done) state <= IDLE;
                end
                default: state <= CALIB;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            hold_write <= req_write;
            hold_addr  <= req_addr;
            hold_data  <= req_data;
            hold_be    <= req_be;
        end
    end

    // A credit is taken when the read command is issued and returned when its data leaves.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rd_credits_used <= '0;
        end else if (rd_issue && !credit_dec) begin
            rd_credits_used <= rd_credits_used + 1'b1;
        end else if (!rd_issue && credit_dec) begin
            rd_credits_used <= rd_credits_used - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err_rd_overflow <= 1'b0;
        end else if (app_rd_data_valid && fifo_full && !deq) begin
            err_rd_overflow <= 1'b1;
        end
    end

    ddr_resp_fifo #(
        .DATA_W   (DATA_W),
        .RD_DEPTH (RD_DEPTH)
    ) u_resp_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .wr_en   (app_rd_data_valid),
        .wr_data (app_rd_data),
        .rd_en   (resp_ready),
        .rd_data (resp_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_ddr_app_ctrl.sv
// Bench: reference memory + in-order response scoreboard against a behavioural MIG model.
module tb_ddr_app_ctrl;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [23:0]  req_addr = '0;
    logic [255:0] req_data = '0;
    logic [31:0]  req_be = '0;
    logic         resp_valid, resp_ready = 1'b0;
    logic [255:0] resp_data;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_rdy = 1'b0;
    logic [255:0] app_wdf_data;
    logic [31:0]  app_wdf_mask;
    logic         app_wdf_wren, app_wdf_end, app_wdf_rdy = 1'b0;
    logic [255:0] app_rd_data = '0;
    logic         app_rd_data_valid = 1'b0, app_rd_data_end = 1'b0;
    logic         init_calib_complete = 1'b0;
    logic         calib_done;
    logic [3:0]   rd_credits_used;
    logic         err_rd_overflow;

    ddr_app_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete),
        .calib_done(calib_done), .rd_credits_used(rd_credits_used),
        .err_rd_overflow(err_rd_overflow)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [255:0] ref_mem [logic [23:0]];
    logic [255:0] mig_mem [logic [23:0]];
    logic [255:0] exp_q [$];
    logic [255:0] mig_q [$];
    int           cred_m = 0;
    int           inj_n = 0;
    bit           acc = 1'b0, rnd_mode = 1'b0, chk_cred = 1'b0;
    bit           w_cmd_ok = 1'b0, w_dat_ok = 1'b0;
    logic [23:0]  w_addr;
    logic [255:0] w_dat;
    logic [31:0]  w_msk;

    function automatic logic [255:0] dflt(input logic [23:0] a);
        return {8{8'h5C, a}};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes at the falling edge, then act as the MIG after the rising edge.
    task automatic tick();
        logic [255:0] v;
        @(negedge CLK);
        if (!RST_N) begin
            cred_m = 0; exp_q.delete(); mig_q.delete(); w_cmd_ok = 0; w_dat_ok = 0;
        end else begin
            if (req_valid && req_ready) begin
                acc = 1'b1;
                v = ref_mem.exists(req_addr) ? ref_mem[req_addr] : dflt(req_addr);
                if (req_write) begin
                    for (int b = 0; b < 32; b++) if (req_be[b]) v[b*8 +: 8] = req_data[b*8 +: 8];
                    ref_mem[req_addr] = v;
                end else begin
                    exp_q.push_back(v);
                end
            end
            if (app_en && app_rdy) begin
                if (app_cmd == 3'b001) begin
                    mig_q.push_back(mig_mem.exists(app_addr[26:3]) ? mig_mem[app_addr[26:3]] : dflt(app_addr[26:3]));
                    cred_m++;
                end else begin
                    w_addr = app_addr[26:3]; w_cmd_ok = 1'b1;
                end
            end
            if (app_wdf_wren && app_wdf_rdy) begin
                w_dat = app_wdf_data; w_msk = app_wdf_mask; w_dat_ok = 1'b1;
            end
            if (w_cmd_ok && w_dat_ok) begin
                v = mig_mem.exists(w_addr) ? mig_mem[w_addr] : dflt(w_addr);
                for (int b = 0; b < 32; b++) if (!w_msk[b]) v[b*8 +: 8] = w_dat[b*8 +: 8];
                mig_mem[w_addr] = v;
                w_cmd_ok = 1'b0; w_dat_ok = 1'b0;
            end
            if (resp_valid && resp_ready) begin
                chk("resp_pending", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) chk("resp_data", resp_data, exp_q.pop_front());
                if (cred_m > 0) cred_m--;
            end
        end
        @(posedge CLK);
        #1;
        app_rd_data_valid = 1'b0;
        if (inj_n > 0) begin
            app_rd_data_valid = 1'b1; app_rd_data = 256'hDEAD_BEEF; inj_n--;
        end else if (mig_q.size() > 0 && $urandom_range(0, 2) != 0) begin
            app_rd_data_valid = 1'b1; app_rd_data = mig_q.pop_front();
        end
        if (rnd_mode) begin
            app_rdy     = ($urandom_range(0, 2) != 0);
            app_wdf_rdy = ($urandom_range(0, 2) != 0);
            resp_ready  = ($urandom_range(0, 1) != 0);
        end
        if (chk_cred) chk("credits", rd_credits_used, cred_m);
    endtask

    task automatic do_req(input logic w, input logic [23:0] a, input logic [255:0] d, input logic [31:0] be);
        req_valid = 1'b1; req_write = w; req_addr = a; req_data = d; req_be = be; acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) tick();
        req_valid = 1'b0;
        chk("req_accept", acc, 1'b1);
    endtask

    task automatic drain();
        resp_ready = 1'b1;
        for (int i = 0; i < 300 && (exp_q.size() > 0 || cred_m > 0); i++) tick();
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_resp_valid", resp_valid, 1'b0);
    endtask

    initial begin
        logic [255:0] rd;
        // Reset state
        repeat (3) tick();
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_app_en", app_en, 1'b0);
        chk("rst_wdf_wren", app_wdf_wren, 1'b0);
        chk("rst_wdf_end", app_wdf_end, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_credits", rd_credits_used, 4'd0);
        chk("rst_err", err_rd_overflow, 1'b0);
        chk("rst_calib_done", calib_done, 1'b0);

        // Calibration hold-off with a request waiting
        RST_N = 1'b1; chk_cred = 1'b1;
        req_valid = 1'b1; acc = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("calib_req_ready", req_ready, 1'b0);
            chk("calib_done_low", calib_done, 1'b0);
        end
        chk("calib_no_accept", acc, 1'b0);
        req_valid = 1'b0;
        init_calib_complete = 1'b1;
        tick();
        chk("calib_done_1cyc", calib_done, 1'b0);
        tick();
        chk("calib_done_2cyc", calib_done, 1'b1);
        chk("idle_req_ready", req_ready, 1'b1);

        // Directed write with delayed write-data acceptance
        app_rdy = 1'b1; app_wdf_rdy = 1'b0;
        do_req(1'b1, 24'h000123, {8{32'h1234_5678}}, 32'hFFFF_0000);
        chk("wr_app_en", app_en, 1'b1);
        chk("wr_wdf_wren", app_wdf_wren, 1'b1);
        chk("wr_wdf_end", app_wdf_end, 1'b1);
        chk("wr_app_addr", app_addr, 28'h0000918);
        chk("wr_app_cmd", app_cmd, 3'b000);
        chk("wr_mask", app_wdf_mask, 32'h0000_FFFF);
        tick();
        chk("wr_cmd_done", app_en, 1'b0);
        chk("wr_data_wait", app_wdf_wren, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("wr_busy_ready", req_ready, 1'b0);
            chk("wr_wren_held", app_wdf_wren, 1'b1);
        end
        app_wdf_rdy = 1'b1;
        tick();
        chk("wr_wren_done", app_wdf_wren, 1'b0);
        chk("wr_idle", req_ready, 1'b1);

        // Randomised mixed traffic, calibration input dropped part-way
        rnd_mode = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (n == 30) init_calib_complete = 1'b0;
            do_req($urandom_range(0, 1) == 1,
                   ($urandom_range(0, 3) == 0) ? 24'h000123 : 24'($urandom_range(0, 15)),
                   {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                   $urandom);
        end
        rnd_mode = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        drain();
        chk("calib_sticky", calib_done, 1'b1);

        // Credit exhaustion with the consumer stalled
        resp_ready = 1'b0;
        for (int n = 0; n < 8; n++) do_req(1'b0, 24'($urandom_range(0, 31)), '0, '0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h7; acc = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("stall_req_ready", req_ready, 1'b0);
            chk("stall_credits", rd_credits_used, 4'd8);
        end
        chk("stall_no_accept", acc, 1'b0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("unstall_req_ready", req_ready, 1'b1);
        for (int i = 0; i < 20 && !acc; i++) tick();
        req_valid = 1'b0;
        chk("unstall_accept", acc, 1'b1);
        drain();

        // Response ordering
        foreach (ref_mem[a]) if (a == 24'h10 || a == 24'h11 || a == 24'h12) ref_mem.delete(a);
        ref_mem[24'h10] = 256'hA; mig_mem[24'h10] = 256'hA;
        ref_mem[24'h11] = 256'hB; mig_mem[24'h11] = 256'hB;
        ref_mem[24'h12] = 256'hC; mig_mem[24'h12] = 256'hC;
        resp_ready = 1'b0;
        for (int n = 0; n < 3; n++) do_req(1'b0, 24'h10 + 24'(n), '0, '0);
        repeat (12) tick();
        resp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            rd = 256'hA + 256'(n);
            chk("order_valid", resp_valid, 1'b1);
            chk("order_data", resp_data, rd);
            tick();
        end
        chk("order_empty", resp_valid, 1'b0);

        // Overflow: fill the buffer, then an unsolicited beat
        resp_ready = 1'b0;
        for (int n = 0; n < 8; n++) do_req(1'b0, 24'($urandom_range(32, 63)), '0, '0);
        repeat (20) tick();
        chk("ovf_mig_idle", mig_q.size(), 0);
        chk("ovf_err_before", err_rd_overflow, 1'b0);
        inj_n = 1;
        tick();
        tick();
        chk("ovf_err_set", err_rd_overflow, 1'b1);
        drain();
        chk("ovf_err_sticky", err_rd_overflow, 1'b1);

        // Reset in the middle of a stalled write
        app_rdy = 1'b0; app_wdf_rdy = 1'b0; resp_ready = 1'b0;
        do_req(1'b1, 24'h55, {8{32'hCAFE_F00D}}, 32'hFFFF_FFFF);
        tick(); tick();
        chk("midwr_app_en", app_en, 1'b1);
        RST_N = 1'b0;
        tick();
        chk("midrst_app_en", app_en, 1'b0);
        chk("midrst_wdf_wren", app_wdf_wren, 1'b0);
        chk("midrst_calib_done", calib_done, 1'b0);
        chk("midrst_credits", rd_credits_used, 4'd0);
        chk("midrst_err", err_rd_overflow, 1'b0);
        chk("midrst_resp_valid", resp_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b0);
        RST_N = 1'b1; init_calib_complete = 1'b1;
        repeat (3) tick();
        chk("recal_done", calib_done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_app_ctrl.md
DDR_APP_CTRL -- requirements
Module: ddr_app_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 24: user line-address width.
REQ-002 SHALL have parameter DATA_W, default 256: line width; DATA_W/8 mask bits.
REQ-003 SHALL have parameter APP_ADDR_W, default 28: MIG app_addr width; must be >= ADDR_W+ADDR_LSB.
REQ-004 SHALL have parameter ADDR_LSB, default 3: zero bits appended below the line address.
REQ-005 SHALL have parameter RD_DEPTH, default 8, power of two >= 2: read-response buffer depth and read-credit limit.
REQ-006 SHALL use one clock and a synchronous, active-low reset; ports: CLK in 1 clock (= MIG ui_clk); RST_N in 1 synchronous active-low reset.
REQ-007 Ports (user side): req_valid in 1; req_ready out 1; req_write in 1 (1=write); req_addr in ADDR_W; req_data in DATA_W; req_be in DATA_W/8 (1=byte written).
REQ-008 Ports (user side): resp_valid out 1; resp_ready in 1; resp_data out DATA_W.
REQ-009 Ports (MIG side): app_addr out APP_ADDR_W; app_cmd out 3; app_en out 1; app_rdy in 1; app_wdf_data out DATA_W; app_wdf_mask out DATA_W/8; app_wdf_wren out 1; app_wdf_end out 1; app_wdf_rdy in 1.
REQ-010 Ports (MIG side): app_rd_data in DATA_W; app_rd_data_valid in 1; app_rd_data_end in 1 (ignored); init_calib_complete in 1.
REQ-011 Ports (status): calib_done out 1; rd_credits_used out clog2(RD_DEPTH)+1; err_rd_overflow out 1 (sticky).

Function
REQ-012 SHALL implement FSM states CALIB, IDLE, READ, WRITE; CALIB -> IDLE when registered init_calib_complete is 1; calib_done = (state != CALIB).
REQ-013 req_ready SHALL be 1 only in IDLE with rd_credits_used < RD_DEPTH; registered-state based, no combinational path from req_valid.
REQ-014 On req_valid & req_ready, SHALL capture addr/data/be/write into a holding register and go to READ or WRITE next cycle.
REQ-015 app_addr SHALL be {zero pad, held addr, ADDR_LSB zeros}; app_cmd = 3'b001 read, 3'b000 write.
REQ-016 READ: app_en=1 from the cycle after acceptance until app_en & app_rdy; that cycle -> IDLE; rd_credits_used +1.
REQ-017 WRITE: app_en and app_wdf_wren both asserted from the cycle after acceptance; each deasserts independently after its own handshake (app_rdy / app_wdf_rdy); -> IDLE the cycle both have completed (same cycle or either order).
REQ-018 app_wdf_end SHALL equal app_wdf_wren (single-beat lines); app_wdf_mask = ~held be.
REQ-019 Every app_rd_data_valid beat SHALL be written to the response FIFO in arrival order, no backpressure; if the FIFO is full the beat is dropped and err_rd_overflow set until reset.
REQ-020 rd_credits_used SHALL decrement on resp_valid & resp_ready; simultaneous read-issue and dequeue leave it unchanged; it never exceeds RD_DEPTH.
REQ-021 resp_valid = FIFO non-empty; resp_data = FIFO head (first-word fall-through); enqueue and dequeue in the same cycle when full or empty SHALL both succeed only if legal (full: dequeue first then enqueue same cycle allowed).
REQ-022 Minimum request latency: accept cycle N, app_en at N+1; peak rate one request per 2 cycles.
REQ-023 Drop of init_calib_complete after CALIB SHALL be ignored (no return to CALIB except via reset).

Reset
REQ-024 On RST_N=0 at a CLK edge: state=CALIB, req_ready=0, app_en=0, app_wdf_wren=0, resp_valid=0, FIFO empty, rd_credits_used=0, err_rd_overflow=0, calib_done=0; an operation in progress is abandoned.
REQ-025 Holding/data registers need no reset; app_addr/app_wdf_data undefined while strobes are 0.

Structure
REQ-026 Package ddr_app_pkg SHALL hold the app_cmd encodings (CMD_WRITE, CMD_READ) and the FSM state enum.
REQ-027 Response FIFO SHALL be a sub-module ddr_resp_fifo (parameters DATA_W, RD_DEPTH, synchronous active-low reset, count output).

Verification
REQ-028 Hold init_calib_complete=0 for 50 cycles, then 1 -> req_ready=0 throughout, calib_done=1 two cycles after rise.
REQ-029 Write addr 0x000123, be=0xFFFF_0000, app_rdy=1, app_wdf_rdy delayed 5 cycles -> app_addr=0x0000918, app_cmd=000, mask=0x0000_FFFF_..., IDLE after the wdf handshake.
REQ-030 Issue 8 reads (RD_DEPTH=8), resp_ready=0 -> 9th request stalled (req_ready=0, rd_credits_used=8); one dequeue -> req_ready=1 next cycle.
REQ-031 Reads to 0x10,0x11,0x12 with MIG model returning data 0xA,0xB,0xC -> resp_data order A,B,C.
REQ-032 Inject app_rd_data_valid with FIFO full -> err_rd_overflow=1, FIFO contents unchanged.
REQ-033 Assert RST_N=0 mid-WRITE with app_rdy=0 -> next cycle app_en=0, app_wdf_wren=0, state CALIB, counters 0.
